// File: rtl/wb_lsu_pkg.sv
// Shared types and helpers for the Wishbone load/store initiator.
//   size_e  : access size encoding carried on req_size_i (3 is illegal)
//   state_e : initiator FSM states
//   is_misaligned / sel_mask : alignment check and byte-enable generation
package wb_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_BACKOFF,
        S_RESP
    } state_e;

    // Size 3 is treated as misaligned so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] sel_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational byte-lane steering for a 32-bit Wishbone data path.
//   size_i, off_i, unsigned_i : access size, byte offset addr[1:0], zero-extend flag
//   wdata_i -> wdata_o        : right-justified store data -> lane-replicated bus data
//   sel_o                     : byte enables
//   rdata_i -> rdata_o        : bus read data -> right-justified, sign/zero-extended
module wb_lane_align
    import wb_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        sel_o   = sel_mask(size_i, off_i);
        shifted = rdata_i >> {off_i, 3'b000};
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic initiator: converts a load/store request port into single
// non-burst bus cycles, with lane steering, sign extension, rty back-off and
// a no-response watchdog. Exactly one response per accepted request.
//   wb_clk_i, wb_rst_i            : clock, async active-high reset
//   req_*                         : request handshake (valid/ready) and fields
//   rsp_valid_o/rsp_rdata_o/rsp_err_o : one-cycle response
//   wb_*                          : Wishbone classic master port
module wb_lsu_master
    import wb_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RETRY_LIMIT    = 3,
    parameter int unsigned RETRY_BACKOFF  = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  rty_cnt_q, rty_cnt_d;
    logic [7:0]  bo_q, bo_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  al_size;
    logic [1:0]  al_off;
    logic        al_uns;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic [15:0] tmo_inc;

    // One aligner serves both directions: request fields while IDLE (store
    // steering), registered fields afterwards (load extraction on ack).
    assign al_size = (state_q == S_IDLE) ? req_size_i        : size_q;
    assign al_off  = (state_q == S_IDLE) ? req_addr_i[1:0]   : off_q;
    assign al_uns  = (state_q == S_IDLE) ? req_unsigned_i    : uns_q;

    wb_lane_align u_align (
        .size_i     (al_size),
        .off_i      (al_off),
        .unsigned_i (al_uns),
        .wdata_i    (req_wdata_i),
        .rdata_i    (wb_dat_i),
        .sel_o      (al_sel),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    assign tmo_inc = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        size_d    = size_q;
        off_d     = off_q;
        uns_d     = uns_q;
        tmo_d     = tmo_q;
        rty_cnt_d = rty_cnt_q;
        bo_d      = bo_q;
        err_d     = err_q;
        rdata_d   = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    adr_d     = {req_addr_i[31:2], 2'b00};
                    dat_d     = al_wdata;
                    sel_d     = al_sel;
                    we_d      = req_we_i;
                    size_d    = req_size_i;
                    off_d     = req_addr_i[1:0];
                    uns_d     = req_unsigned_i;
                    tmo_d     = '0;
                    rty_cnt_d = '0;
                    rdata_d   = '0;
                    if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cyc_d   = 1'b1;
                        state_d = S_BUS;
                    end
                end
            end

            S_BUS: begin
                tmo_d = tmo_inc;
                if (wb_err_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : al_rdata;
                    state_d = S_RESP;
                end else if (wb_rty_i) begin
                    cyc_d = 1'b0;
                    if (32'(rty_cnt_q) < RETRY_LIMIT) begin
                        rty_cnt_d = rty_cnt_q + 8'd1;
                        bo_d      = '0;
                        state_d   = S_BACKOFF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end else if (32'(tmo_inc) >= TIMEOUT_CYCLES) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end

            S_BACKOFF: begin
                if (32'(bo_q) + 32'd1 >= RETRY_BACKOFF) begin
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_BUS;
                end else begin
                    bo_d = bo_q + 8'd1;
                end
            end

            S_RESP: begin
                tmo_d     = '0;
                rty_cnt_d = '0;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            uns_q     <= 1'b0;
            tmo_q     <= '0;
            rty_cnt_q <= '0;
            bo_q      <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            size_q    <= size_d;
            off_q     <= off_d;
            uns_q     <= uns_d;
            tmo_q     <= tmo_d;
            rty_cnt_q <= rty_cnt_d;
            bo_q      <= bo_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE) & ~wb_rst_i;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_err_o   = rsp_valid_o & err_q;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

endmodule
